// File: rtl/uart_boot_ctrl_if.sv
// Word-write bus: address, data and a single-cycle write strobe.
// Serves as both the UART front-end stream and the instruction-memory write port.
interface uart_boot_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  we;

  modport master (output addr, output data, output we);
  modport slave  (input  addr, input  data, input  we);
endinterface

// File: rtl/uart_boot_ctrl.sv
// Boot-load controller: validates the front-end word stream, forwards it to instruction
// memory, holds the cores in reset while loading and releases them after the end marker.
module uart_boot_ctrl #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [DATA_WIDTH-1:0] END_WORD       = 16'hFFFF,
  parameter int                    RELEASE_CYCLES = 16,
  parameter int                    TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_boot_ctrl_if.slave       prog,
  uart_boot_ctrl_if.master      mem,
  output logic                  cpu_reset,
  output logic                  boot_done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  // The idle counter is cleared by the accepting edge, so the error edge is the one
  // at which it would step to TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_ERR} state_e;
  typedef enum logic [1:0] {E_NONE, E_SEQ, E_OVF, E_TMO} err_e;

  state_e                state;
  logic [TW-1:0]         idle_cnt;
  logic [RW-1:0]         rel_cnt;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  assign mem.we   = mem_we_q;
  assign mem.addr = mem_addr_q;
  assign mem.data = mem_data_q;

  logic wr, start, seq_ok, full;
  assign wr     = prog.we && (prog.data != END_WORD);
  assign start  = wr && (prog.addr == '0);
  assign seq_ok = prog.addr == word_count[ADDR_WIDTH-1:0];
  assign full   = word_count[ADDR_WIDTH];

  logic do_start, do_accept, do_drain, do_release, do_err;
  err_e err_next;

  // NOTE: every decode output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    do_start   = 1'b0;
    do_accept  = 1'b0;
    do_drain   = 1'b0;
    do_release = 1'b0;
    do_err     = 1'b0;
    err_next   = E_NONE;
    case (state)
      S_IDLE: begin
        if (start) do_start = 1'b1;
        else if (wr) begin do_err = 1'b1; err_next = E_SEQ; end
      end
      S_LOAD: begin
        if (wr) begin
          if (full)        begin do_err = 1'b1; err_next = E_OVF; end
          else if (seq_ok) do_accept = 1'b1;
          else             begin do_err = 1'b1; err_next = E_SEQ; end
        end else if (prog.we) begin
          do_drain = 1'b1;
        end else if (idle_cnt == IDLE_LAST) begin
          do_err = 1'b1; err_next = E_TMO;
        end
      end
      S_DRAIN: begin
        // An ignored END_WORD is not a write here, so the countdown proceeds.
        if (start) do_start = 1'b1;
        else if (wr) begin do_err = 1'b1; err_next = E_SEQ; end
        else if (rel_cnt == '0) do_release = 1'b1;
      end
      S_ERR: begin
        if (start) do_start = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; later assignments in the block
  // override the default counter steps, which is how a write beats a counter event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idle_cnt   <= '0;
      rel_cnt    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_reset  <= 1'b0;
      boot_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= E_NONE;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      mem_we_q  <= 1'b0;
      boot_done <= 1'b0;
      if (state == S_LOAD)  idle_cnt <= idle_cnt + TW'(1);
      if (state == S_DRAIN) rel_cnt  <= rel_cnt - RW'(1);

      if (do_start) begin
        state      <= S_LOAD;
        cpu_reset  <= 1'b1;
        err        <= 1'b0;
        err_code   <= E_NONE;
        word_count <= (ADDR_WIDTH+1)'(1);
        checksum   <= prog.data;
        mem_we_q   <= 1'b1;
        mem_addr_q <= prog.addr;
        mem_data_q <= prog.data;
        idle_cnt   <= '0;
      end
      if (do_accept) begin
        word_count <= word_count + (ADDR_WIDTH+1)'(1);
        checksum   <= checksum + prog.data;
        mem_we_q   <= 1'b1;
        mem_addr_q <= prog.addr;
        mem_data_q <= prog.data;
        idle_cnt   <= '0;
      end
      if (do_drain) begin
        state   <= S_DRAIN;
        rel_cnt <= RW'(RELEASE_CYCLES - 1);
      end
      if (do_err) begin
        state     <= S_ERR;
        cpu_reset <= 1'b1;
        err       <= 1'b1;
        err_code  <= err_next;
      end
      if (do_release) begin
        state     <= S_IDLE;
        cpu_reset <= 1'b0;
        boot_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_boot_ctrl.md
# uart_boot_ctrl

Boot-load controller placed directly downstream of the UART programming front-end and upstream of the shared instruction memory. Consumes the front-end's word-write stream (address, 16-bit word, write strobe), checks the image for sequential addressing, overflow and stalls, and forwards valid words to the instruction memory write port. Holds the cores in reset while an image is loading. Releases them a fixed number of cycles after the end-of-image word, and reports word count, checksum and error status.

## Interface
Parameters:
- ADDR_WIDTH, 8: instruction memory address width; capacity is 2^ADDR_WIDTH words.
- DATA_WIDTH, 16: word width.
- END_WORD, 16'hFFFF: end-of-image marker; never written to memory.
- RELEASE_CYCLES, 16: cycles cpu_reset stays high after END_WORD is accepted. Must be at least 1.
- TIMEOUT_CYCLES, 1000000: maximum idle gap between writes while loading.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- prog_addr  in  ADDR_WIDTH  word address from the UART programming front-end.
- prog_data  in  DATA_WIDTH  word from the front-end.
- prog_we  in  1  single-cycle write strobe; prog_addr and prog_data are valid only while it is high.
- mem_addr  out  ADDR_WIDTH  instruction memory write address.
- mem_data  out  DATA_WIDTH  instruction memory write data.
- mem_we  out  1  instruction memory write enable.
- cpu_reset  out  1  active-high hold for the cores.
- boot_done  out  1  single-cycle pulse when the cores are released.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 0 none, 1 address sequence, 2 overflow, 3 timeout.
- word_count  out  ADDR_WIDTH+1  number of words written in the current or last load.
- checksum  out  DATA_WIDTH  sum of written words, modulo 2^DATA_WIDTH.

## Operation
- States: IDLE, LOAD, DRAIN, ERR.
- Reset values: state IDLE, and every output 0.
- "Start write" means prog_we high with prog_data != END_WORD and prog_addr == 0.

IDLE:
- A start write moves to LOAD. It clears word_count, checksum, err and err_code, then writes the word as in LOAD.
- A non-end write with prog_addr != 0 moves to ERR with code 1.
- An END_WORD write is ignored.

LOAD:
- cpu_reset = 1.
- A non-end write with prog_addr == word_count[ADDR_WIDTH-1:0] and word_count < 2^ADDR_WIDTH is accepted. It drives mem_we, mem_addr and mem_data, increments word_count, adds the word to checksum, and clears the timeout counter.
- A non-end write with word_count == 2^ADDR_WIDTH moves to ERR with code 2.
- Any other address mismatch moves to ERR with code 1.
- An END_WORD write moves to DRAIN and loads the release counter. It does not write memory.
- When the idle counter reaches TIMEOUT_CYCLES-1 with no write, the block moves to ERR with code 3.

DRAIN:
- cpu_reset = 1 and the release counter counts down.
- When the counter expires: move to IDLE, set cpu_reset = 0, and pulse boot_done.
- A start write aborts the drain and restarts LOAD.
- Any other non-end write moves to ERR with code 1.
- END_WORD writes are ignored.

ERR:
- cpu_reset = 1 and err = 1. No memory writes occur.
- Only a start write leaves ERR; it restarts LOAD and clears err.
- Everything else is ignored.

Status outputs:
- word_count and checksum hold their values after DRAIN and after ERR, for readback.
- An error never modifies memory.

## Timing
- Registered write path: mem_we, mem_addr and mem_data appear exactly 1 cycle after the accepted prog_we. mem_we is high for exactly 1 cycle.
- cpu_reset rises in the cycle after the start write, which is the same cycle its mem_we is high.
- word_count and checksum update in the same cycle as mem_we.
- Release timing: cpu_reset falls, and boot_done pulses for 1 cycle, exactly RELEASE_CYCLES+1 cycles after the END_WORD strobe cycle.
- A write and a timeout or release expiry in the same cycle: the write wins, and the counter action is discarded.
- err and err_code are registered and update 1 cycle after the offending strobe or timeout.
- Back-to-back prog_we on consecutive cycles must be accepted. The front-end is slower, but this block must not depend on that.
- Asserting reset low mid-load returns the block to IDLE immediately. cpu_reset drops to 0 even if the image is partial; software must reload.

## Test plan
- Load words 0x1111, 0x2222, 0x3333 at addresses 0, 1, 2, then END_WORD. Expect:
  - three mem_we pulses at addresses 0, 1, 2;
  - word_count = 3 and checksum = 0x6666;
  - cpu_reset high from start until RELEASE_CYCLES+1 cycles after END_WORD, then boot_done for 1 cycle;
  - err = 0.
- Write address 0, then address 2. Expect ERR with err_code 1, mem_we for address 0 only, cpu_reset held at 1, and word_count = 1. A following start write recovers into LOAD with err = 0.
- With ADDR_WIDTH = 2, write 4 words, then a 5th non-end word. Expect err_code 2, exactly 4 mem_we pulses, and word_count = 4.
- With TIMEOUT_CYCLES = 8, write 1 word, then idle. Expect ERR with err_code 3 exactly 8 cycles after the write.
- During DRAIN, issue a start write. Expect no boot_done, LOAD restarted with word_count = 1, and cpu_reset staying high throughout.
- Pull reset low mid-load. Expect cpu_reset, mem_we, err and word_count all 0 asynchronously, and the block in IDLE after release.
